// File: rtl/fp_adder_pipe.sv
// fp_adder_pipe: 3-stage pipelined IEEE-754 adder/subtractor with valid/ready flow control.
// S1 unpacks, detects specials and aligns. S2 adds. S3 normalises, rounds (RNE) and packs.
module fp_adder_pipe #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    input  logic                   sub,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   sum,
    output logic [3:0]             flags
);
    // Aligned significand: hidden, mantissa, guard, round, sticky
    localparam int unsigned SW = MAN_W + 4;
    localparam logic [EXP_W-1:0] EXP_ONES = '1;

    typedef struct packed {
        logic             nan;
        logic             inf;
        logic             sign;
        logic             eff_sub;
        logic [EXP_W-1:0] exp;
        logic [SW-1:0]    sig_a;
        logic [SW-1:0]    sig_b;
    } s1_t;

    typedef struct packed {
        logic             nan;
        logic             inf;
        logic             sign;
        logic             eff_sub;
        logic [EXP_W-1:0] exp;
        logic [SW:0]      sum;
    } s2_t;

    logic                 s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
    logic                 out_valid_q, out_valid_d;
    s1_t                  s1_q, s1_d, s1_c;
    s2_t                  s2_q, s2_d, s2_c;
    logic [EXP_W+MAN_W:0] sum_q, sum_d, sum_c;
    logic [3:0]           flags_q, flags_d, flags_c;
    logic                 s1_adv, s2_adv;

    assign s2_adv    = s2_valid_q & (~out_valid_q | out_ready);
    assign s1_adv    = s1_valid_q & (~s2_valid_q | s2_adv);
    assign in_ready  = ~s1_valid_q | s1_adv;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign flags     = flags_q;

    // S1: unpack, special detection, magnitude swap and alignment of the smaller operand
    always_comb begin
        logic             sa, sb, a_nan, b_nan, a_inf, b_inf, swap;
        logic [EXP_W-1:0] ea, eb, big_e, sml_e, big_ee, sml_ee, diff;
        logic [MAN_W-1:0] ma, mb, big_m, sml_m;
        logic [SW-1:0]    sml_sig, sml_al, mask;
        sa      = a[EXP_W+MAN_W];
        sb      = b[EXP_W+MAN_W] ^ sub;
        ea      = a[MAN_W +: EXP_W];
        eb      = b[MAN_W +: EXP_W];
        ma      = a[MAN_W-1:0];
        mb      = b[MAN_W-1:0];
        a_nan   = (ea == EXP_ONES) && (ma != '0);
        b_nan   = (eb == EXP_ONES) && (mb != '0);
        a_inf   = (ea == EXP_ONES) && (ma == '0);
        b_inf   = (eb == EXP_ONES) && (mb == '0);
        swap    = {eb, mb} > {ea, ma};
        big_e   = swap ? eb : ea;
        big_m   = swap ? mb : ma;
        sml_e   = swap ? ea : eb;
        sml_m   = swap ? ma : mb;
        big_ee  = (big_e == '0) ? EXP_W'(1) : big_e;
        sml_ee  = (sml_e == '0) ? EXP_W'(1) : sml_e;
        diff    = big_ee - sml_ee;
        sml_sig = {(sml_e != '0), sml_m, 3'b000};
        mask    = '0;
        if (32'(diff) >= MAN_W + 3) begin
            sml_al = {{(SW-1){1'b0}}, (|sml_sig)};
        end else begin
            mask      = (SW'(1) << diff) - SW'(1);
            sml_al    = sml_sig >> diff;
            sml_al[0] = sml_al[0] | (|(sml_sig & mask));
        end
        s1_c.nan     = a_nan | b_nan | (a_inf & b_inf & (sa != sb));
        s1_c.inf     = a_inf | b_inf;
        // For a lone Inf the sign field carries the Inf's sign
        s1_c.sign    = a_inf ? sa : (b_inf ? sb : (swap ? sb : sa));
        s1_c.eff_sub = sa ^ sb;
        s1_c.exp     = big_ee;
        s1_c.sig_a   = {(big_e != '0), big_m, 3'b000};
        s1_c.sig_b   = sml_al;
    end

    // S2: add or subtract the aligned significands (sig_a >= sig_b by construction)
    always_comb begin
        s2_c.nan     = s1_q.nan;
        s2_c.inf     = s1_q.inf;
        s2_c.sign    = s1_q.sign;
        s2_c.eff_sub = s1_q.eff_sub;
        s2_c.exp     = s1_q.exp;
        s2_c.sum     = s1_q.eff_sub ? ({1'b0, s1_q.sig_a} - {1'b0, s1_q.sig_b})
                                    : ({1'b0, s1_q.sig_a} + {1'b0, s1_q.sig_b});
    end

    // S3: normalise, round to nearest even, pack and raise flags
    always_comb begin
        logic [SW-1:0]    norm;
        logic [EXP_W:0]   exp_n, exp_f;
        logic [MAN_W+1:0] rnd;
        logic [MAN_W-1:0] man_f;
        logic             inexact, sign_f;
        int unsigned      lzc, lim, shamt;
        lzc   = SW;
        lim   = 0;
        shamt = 0;
        if (s2_q.sum[SW]) begin
            norm  = {s2_q.sum[SW:2], s2_q.sum[1] | s2_q.sum[0]};
            exp_n = {1'b0, s2_q.exp} + 1'b1;
        end else begin
            for (int i = 0; i < SW; i++) begin
                if (s2_q.sum[i]) lzc = SW - 1 - i;
            end
            // Exponent may not drop below 1; a leftover leading zero means subnormal
            lim   = 32'(s2_q.exp) - 1;
            shamt = (lzc < lim) ? lzc : lim;
            norm  = s2_q.sum[SW-1:0] << shamt;
            exp_n = {1'b0, s2_q.exp} - (EXP_W+1)'(shamt);
        end
        inexact = norm[2] | norm[1] | norm[0];
        rnd     = {1'b0, norm[SW-1:3]} + (MAN_W+2)'(norm[2] & (norm[1] | norm[0] | norm[3]));
        if (rnd[MAN_W+1]) begin
            exp_f = exp_n + 1'b1;
            man_f = rnd[MAN_W:1];
        end else begin
            exp_f = rnd[MAN_W] ? exp_n : '0;
            man_f = rnd[MAN_W-1:0];
        end
        // Exact cancellation yields +0; like-signed zeros keep their sign
        sign_f = (rnd == '0 && s2_q.eff_sub) ? 1'b0 : s2_q.sign;
        if (s2_q.nan) begin
            sum_c   = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
            flags_c = 4'b1000;
        end else if (s2_q.inf) begin
            sum_c   = {s2_q.sign, EXP_ONES, {MAN_W{1'b0}}};
            flags_c = 4'b0000;
        end else if (exp_f >= {1'b0, EXP_ONES}) begin
            sum_c   = {sign_f, EXP_ONES, {MAN_W{1'b0}}};
            flags_c = 4'b0101;
        end else begin
            sum_c   = {sign_f, exp_f[EXP_W-1:0], man_f};
            flags_c = {2'b00, (exp_f == '0) & inexact, inexact};
        end
    end

    // Pipeline advance: each stage loads when it is empty or its content moves on
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_d        = s1_q;
        s2_valid_d  = s2_valid_q;
        s2_d        = s2_q;
        out_valid_d = out_valid_q;
        sum_d       = sum_q;
        flags_d     = flags_q;
        if (in_ready) begin
            s1_valid_d = in_valid;
            if (in_valid) s1_d = s1_c;
        end
        if (~s2_valid_q | s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) s2_d = s2_c;
        end
        if (~out_valid_q | out_ready) begin
            out_valid_d = s2_valid_q;
            sum_d       = s2_valid_q ? sum_c : '0;
            flags_d     = s2_valid_q ? flags_c : '0;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            s1_q        <= '0;
            s2_q        <= '0;
            sum_q       <= '0;
            flags_q     <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s2_valid_q  <= s2_valid_d;
            out_valid_q <= out_valid_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            sum_q       <= sum_d;
            flags_q     <= flags_d;
        end
    end
endmodule

// File: tb/tb_fp_adder_pipe.sv
// Self-checking bench for fp_adder_pipe (single precision). Results are compared against a
// queue of expectations from a vector table or from a real-arithmetic reference model.
module tb_fp_adder_pipe;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, sub, out_valid, out_ready;
    logic [31:0] a, b, sum;
    logic [3:0]  flags;

    always #5 clk = ~clk;

    fp_adder_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .flags(flags)
    );

    typedef struct { logic [31:0] sum; logic [3:0] flags; } exp_t;
    typedef struct { logic [31:0] a; logic [31:0] b; logic sub; logic [31:0] sum;
                     logic [3:0] flags; } vec_t;

    exp_t exp_q[$];
    int   n_tests = 0, n_fail = 0, n_out = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Reference model: exact real arithmetic on operand values, then RNE to single
    function automatic real f2r(input logic [31:0] f);
        real m;
        int  e;
        m = real'(f[22:0]);
        if (f[30:23] == 8'd0) e = -149;
        else begin
            m = m + 8388608.0;
            e = int'(f[30:23]) - 150;
        end
        return (f[31] ? -m : m) * (2.0 ** real'(e));
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] bits, sig, kept, rem, half;
        int          fe, sh;
        logic        s;
        bits = $realtobits(r);
        s    = bits[63];
        if (bits[62:0] == 63'd0) return {s, 31'd0};
        fe   = int'(bits[62:52]) - 1023 + 127;
        sig  = {11'd0, 1'b1, bits[51:0]};
        sh   = (fe >= 1) ? 29 : 30 - fe;
        if (sh > 60) sh = 60;
        kept = sig >> sh;
        rem  = sig & ((64'd1 << sh) - 64'd1);
        half = 64'd1 << (sh - 1);
        if (rem > half || (rem == half && kept[0])) kept = kept + 64'd1;
        if (fe >= 1) begin
            if (kept[24]) begin
                kept = kept >> 1;
                fe++;
            end
            if (fe >= 255) return {s, 8'hFF, 23'd0};
            return {s, 8'(fe), kept[22:0]};
        end
        return {s, kept[30:0]};
    endfunction

    function automatic exp_t model(input logic [31:0] av, input logic [31:0] bv, input logic s);
        exp_t        e;
        logic [31:0] bb, r;
        logic        an, bn, ai, bi, inex;
        real         x, y, t, bvv, avv, err;
        bb = bv ^ {s, 31'd0};
        an = (av[30:23] == 8'hFF) && (av[22:0] != 0);
        bn = (bb[30:23] == 8'hFF) && (bb[22:0] != 0);
        ai = (av[30:23] == 8'hFF) && (av[22:0] == 0);
        bi = (bb[30:23] == 8'hFF) && (bb[22:0] == 0);
        if (an || bn || (ai && bi && av[31] != bb[31])) begin
            e.sum = 32'h7FC00000; e.flags = 4'b1000; return e;
        end
        if (ai) begin e.sum = av; e.flags = 4'b0000; return e; end
        if (bi) begin e.sum = bb; e.flags = 4'b0000; return e; end
        x   = f2r(av);
        y   = f2r(bb);
        t   = x + y;
        bvv = t - x;
        avv = t - bvv;
        err = (x - avv) + (y - bvv);
        r   = r2f(t);
        if (r[30:23] == 8'hFF) begin e.sum = r; e.flags = 4'b0101; return e; end
        inex    = (err != 0.0) || (f2r(r) != t);
        e.sum   = r;
        e.flags = {2'b00, inex && (r[30:23] == 8'd0), inex};
        return e;
    endfunction

    function automatic logic [31:0] rnd_fp(input int near);
        logic [31:0] sp [8] = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800000,
                                32'h7FC00000, 32'h7F800001, 32'h7F7FFFFF, 32'h00000001};
        logic [31:0] v;
        int unsigned m;
        int          ex;
        m = $urandom_range(0, 15);
        v = $urandom;
        if (m == 0) v = sp[$urandom_range(0, 7)];
        else if (m == 1) v[30:23] = 8'd0;
        else if (m <= 9 && near > 0) begin
            ex = near + int'($urandom_range(0, 4)) - 2;
            if (ex < 1) ex = 1;
            if (ex > 254) ex = 254;
            v[30:23] = 8'(ex);
        end else v[30:23] = 8'($urandom_range(1, 254));
        return v;
    endfunction

    // Output monitor: in-order scoreboard, hold-stability under stall, idle flags
    logic [35:0] held_val;
    logic        held = 1'b0;
    always @(negedge clk) begin
        #2;
        if (rst_n) begin
            if (held && out_valid) check("hold_stable", {flags, sum}, held_val);
            held     = out_valid && !out_ready;
            held_val = {flags, sum};
            if (!out_valid) check("idle_flags", flags, 4'd0);
            if (out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_output: got sum %h, required no output", sum);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("result", {flags, sum}, {e.flags, e.sum});
                end
            end
        end else held = 1'b0;
    end

    task automatic send(input logic [31:0] av, input logic [31:0] bv, input logic s,
                        input exp_t e, input logic bp);
        int cyc = 0;
        bit acc = 0;
        while (!acc) begin
            @(negedge clk);
            a = av; b = bv; sub = s; in_valid = 1'b1;
            out_ready = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
            #1 acc = in_ready;
            @(posedge clk);
            if (acc) exp_q.push_back(e);
            cyc++;
            if (!acc && cyc > 100) begin
                n_tests++;
                n_fail++;
                $display("FAIL send_timeout: got in_ready=0 for %0d cycles, required 1", cyc);
                break;
            end
        end
    endtask

    task automatic drain();
        int cyc = 0;
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        while (exp_q.size() != 0 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("drain_empty", exp_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    vec_t vecs[12];

    initial begin
        logic [31:0] bpa [5], bpb [5];
        exp_t        e;
        int          k, outs0;
        bit          acc;

        vecs[0]  = '{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000};
        vecs[1]  = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000};
        vecs[2]  = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001};
        vecs[3]  = '{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0001};
        vecs[4]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101};
        vecs[5]  = '{32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'b1000};
        vecs[6]  = '{32'h00800000, 32'h80400000, 1'b0, 32'h00400000, 4'b0000};
        vecs[7]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000};
        vecs[8]  = '{32'h7F800000, 32'hFF800000, 1'b1, 32'h7F800000, 4'b0000};
        vecs[9]  = '{32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000};
        vecs[10] = '{32'h00000001, 32'h00000001, 1'b1, 32'h00000000, 4'b0000};
        vecs[11] = '{32'h3F800000, 32'h3F800001, 1'b1, 32'hB4000000, 4'b0000};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sub = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_sum", sum, 32'd0);
        check("rst_flags", flags, 4'd0);
        check("rst_in_ready", in_ready, 1'b1);
        rst_n = 1'b1;

        // Latency: accepted on first edge, visible after the third
        @(negedge clk);
        a = 32'h3F800000; b = 32'h3F800000; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        #1 check("lat_accept", in_ready, 1'b1);
        @(posedge clk);
        e.sum = 32'h40000000; e.flags = 4'b0000;
        exp_q.push_back(e);
        @(negedge clk); in_valid = 1'b0;
        check("lat_cycle1", out_valid, 1'b0);
        @(negedge clk); check("lat_cycle2", out_valid, 1'b0);
        @(negedge clk); check("lat_cycle3", out_valid, 1'b1);
        drain();

        for (int i = 0; i < 12; i++) begin
            e.sum = vecs[i].sum; e.flags = vecs[i].flags;
            send(vecs[i].a, vecs[i].b, vecs[i].sub, e, 1'b0);
        end
        drain();

        // Backpressure: 5 offered over 6 stalled cycles, only 3 fit
        for (int i = 0; i < 5; i++) begin
            bpa[i] = rnd_fp(0);
            bpb[i] = rnd_fp(int'(bpa[i][30:23]));
        end
        outs0 = n_out;
        k = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            out_ready = 1'b0;
            a = bpa[k]; b = bpb[k]; sub = 1'b0; in_valid = 1'b1;
            #1 acc = in_ready;
            @(posedge clk);
            if (acc) begin
                exp_q.push_back(model(bpa[k], bpb[k], 1'b0));
                k++;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("bp_accepted", k, 3);
        check("bp_in_ready", in_ready, 1'b0);
        check("bp_out_valid", out_valid, 1'b1);
        for (int j = k; j < 5; j++) send(bpa[j], bpb[j], 1'b0, model(bpa[j], bpb[j], 1'b0), 1'b0);
        drain();
        check("bp_out_count", n_out - outs0, 5);

        // Randomized traffic with random downstream stalls
        for (int i = 0; i < 400; i++) begin
            logic [31:0] ra, rb;
            logic        rs;
            ra = rnd_fp(0);
            rb = rnd_fp(int'(ra[30:23]));
            rs = 1'($urandom_range(0, 1));
            send(ra, rb, rs, model(ra, rb, rs), 1'b1);
        end
        drain();

        // Reset in the middle of a stream discards everything in flight
        for (int i = 0; i < 4; i++) begin
            logic [31:0] ra, rb;
            ra = rnd_fp(0);
            rb = rnd_fp(0);
            send(ra, rb, 1'b0, model(ra, rb, 1'b0), 1'b0);
        end
        @(negedge clk);
        in_valid = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_in_ready", in_ready, 1'b1);
        exp_q.delete();
        outs0 = n_out;
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("midrst_no_output", n_out - outs0, 0);
        check("midrst_idle", out_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
